// File: rtl/multi_range_sensor.sv
// Round-robin ultrasonic range finder: triggers one sensor at a time, times the echo,
// converts the centimetre count to BCD and keeps a per-channel result store.
module multi_range_sensor #(
  parameter int CHANNELS     = 2,
  parameter int TRIG_CYCLES  = 1000,
  parameter int TICKS_PER_CM = 5800,
  parameter int MAX_CM       = 400,
  parameter int RISE_TIMEOUT = 3000000,
  parameter int GAP_CYCLES   = 6000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [CHANNELS-1:0]     pulse_pin,
  input  logic [2:0]              sel,
  output logic [CHANNELS-1:0]     trigger_pin,
  output logic [10*CHANNELS-1:0]  dist_cm,
  output logic [CHANNELS-1:0]     timeout,
  output logic [CHANNELS-1:0]     valid,
  output logic [3:0]              meters,
  output logic [3:0]              decimeters,
  output logic [3:0]              centimeters
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, CONVERT, GAP} state_t;

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] RISE_LAST = 32'(RISE_TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_CM - 1);
  localparam logic [31:0] CONV_LAST = 32'd9;
  localparam logic [9:0]  MAX_VAL   = 10'(MAX_CM);
  localparam logic [2:0]  CH_LAST   = 3'(CHANNELS - 1);

  state_t               state, state_next;
  logic [CHANNELS-1:0]  sync1, sync2;
  logic [2:0]           ch;
  logic [31:0]          cnt, presc;
  logic [9:0]           cm, res, bin;
  logic [11:0]          bcd;
  logic                 flag;
  logic [11:0]          bcd_store [CHANNELS];
  logic                 echo, tick, presc_wrap, sat;
  logic [9:0]           conv_val;
  logic                 conv_flag;
  logic [21:0]          dd_next;
  logic [11:0]          sel_digits;

  // One double-dabble iteration on {bcd, bin}: add-3 correction, then shift left.
  function automatic logic [21:0] dd_step(input logic [21:0] v);
    logic [21:0] t;
    t = v;
    for (int unsigned d = 0; d < 3; d++) begin
      if (t[10+4*d +: 4] >= 4'd5) t[10+4*d +: 4] = t[10+4*d +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  always_comb begin
    echo = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ch == 3'(i)) echo = sync2[i];
    end
  end

  // The rising-edge clock seen in WAIT_RISE is itself an echo-high clock and is counted.
  assign tick       = ((state == WAIT_RISE) || (state == MEASURE)) && echo;
  assign presc_wrap = (presc == TICK_LAST);
  assign sat        = tick && presc_wrap && (cm == MAX_VAL - 10'd1);
  assign dd_next    = dd_step({bcd, bin});

  always_comb begin
    state_next = state;
    conv_val   = '0;
    conv_flag  = 1'b0;
    case (state)
      IDLE:      if (enable) state_next = TRIG;
      TRIG:      if (cnt == TRIG_LAST) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (sat) begin
          state_next = CONVERT;
          conv_val   = MAX_VAL;
          conv_flag  = 1'b1;
        end else if (echo) begin
          state_next = MEASURE;
        end else if (cnt == RISE_LAST) begin
          state_next = CONVERT;
          conv_flag  = 1'b1;
        end
      end
      MEASURE: begin
        if (sat) begin
          state_next = CONVERT;
          conv_val   = MAX_VAL;
          conv_flag  = 1'b1;
        end else if (!echo) begin
          state_next = CONVERT;
          conv_val   = cm;
        end
      end
      CONVERT:   if (cnt == CONV_LAST) state_next = GAP;
      GAP:       if (cnt == GAP_LAST) state_next = enable ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      ch      <= '0;
      cnt     <= '0;
      presc   <= '0;
      cm      <= '0;
      res     <= '0;
      bin     <= '0;
      bcd     <= '0;
      flag    <= 1'b0;
      dist_cm <= '0;
      timeout <= '0;
      valid   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) bcd_store[i] <= '0;
    end else begin
      sync1 <= pulse_pin;
      sync2 <= sync1;
      cnt   <= (state_next != state) ? '0 : cnt + 32'd1;
      valid <= '0;
      case (state)
        TRIG: begin
          presc <= '0;
          cm    <= '0;
        end
        WAIT_RISE, MEASURE: begin
          if (tick) begin
            if (presc_wrap) begin
              presc <= '0;
              cm    <= cm + 10'd1;
            end else begin
              presc <= presc + 32'd1;
            end
          end
        end
        CONVERT: begin
          {bcd, bin} <= dd_next;
          if (cnt == CONV_LAST) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
              if (ch == 3'(i)) begin
                dist_cm[10*i +: 10] <= res;
                timeout[i]          <= flag;
                bcd_store[i]        <= dd_next[21:10];
                valid[i]            <= 1'b1;
              end
            end
          end
        end
        GAP: if (cnt == GAP_LAST) ch <= (ch == CH_LAST) ? '0 : ch + 3'd1;
        default: ;
      endcase
      if ((state != CONVERT) && (state_next == CONVERT)) begin
        bin  <= conv_val;
        res  <= conv_val;
        bcd  <= '0;
        flag <= conv_flag;
      end
    end
  end

  always_comb begin
    trigger_pin = '0;
    if (state == TRIG) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (ch == 3'(i)) trigger_pin[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_digits = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel == 3'(i)) sel_digits = bcd_store[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) {meters, decimeters, centimeters} <= '0;
    else       {meters, decimeters, centimeters} <= sel_digits;
  end

endmodule

// File: tb/tb_multi_range_sensor.sv
// Directed bench for multi_range_sensor with short timing parameters.
module tb_multi_range_sensor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pulse_pin = '0;
  logic [2:0]  sel = '0;
  logic [1:0]  trigger_pin;
  logic [19:0] dist_cm;
  logic [1:0]  timeout;
  logic [1:0]  valid;
  logic [3:0]  meters, decimeters, centimeters;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  multi_range_sensor #(
    .CHANNELS(2), .TRIG_CYCLES(4), .TICKS_PER_CM(3),
    .MAX_CM(20), .RISE_TIMEOUT(50), .GAP_CYCLES(10)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .pulse_pin(pulse_pin), .sel(sel),
    .trigger_pin(trigger_pin), .dist_cm(dist_cm), .timeout(timeout), .valid(valid),
    .meters(meters), .decimeters(decimeters), .centimeters(centimeters)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (&trigger_pin) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the first negedge with all triggers low, i.e. right after the pulse ends.
  task automatic wait_trig(output int c, output int w);
    int n;
    n = 0; c = -1; w = 0;
    while (trigger_pin == 2'b00 && n < 400) begin
      @(negedge clock); n++;
    end
    if (trigger_pin == 2'b00) begin
      check("trig_seen", 0, 1);
      return;
    end
    c = trigger_pin[1] ? 1 : 0;
    while (trigger_pin != 2'b00 && w < 100) begin
      w++; @(negedge clock);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (valid == 2'b00 && n < 400) begin
      @(negedge clock); n++;
    end
    if (valid == 2'b00) check("valid_seen", 0, 1);
  endtask

  initial begin
    int c, w, n;

    repeat (3) @(negedge clock);
    check("rst_trig", trigger_pin, 0);
    check("rst_dist", dist_cm, 0);
    check("rst_to", timeout, 0);
    check("rst_valid", valid, 0);
    check("rst_digits", {meters, decimeters, centimeters}, 0);
    reset = 1'b0;
    enable = 1'b1;

    // ch0: 37 echo-high clocks -> 12 cm
    wait_trig(c, w);
    check("t1_ch", c, 0);
    check("t1_width", w, 4);
    pulse_pin[0] = 1'b1;
    repeat (37) @(negedge clock);
    pulse_pin[0] = 1'b0;
    wait_valid(n);
    check("m1_valid", valid, 2'b01);
    check("m1_dist", dist_cm[9:0], 12);
    check("m1_to", timeout[0], 0);
    @(negedge clock);
    check("m1_valid_off", valid, 0);
    check("m1_digits", {meters, decimeters, centimeters}, 12'h012);

    // ch1: echo held 100 clocks -> saturates at 20
    wait_trig(c, w);
    check("t2_ch", c, 1);
    check("t2_width", w, 4);
    pulse_pin[1] = 1'b1;
    fork
      begin
        repeat (100) @(negedge clock);
        pulse_pin[1] = 1'b0;
      end
    join_none
    wait_valid(n);
    check("m2_valid", valid, 2'b10);
    check("m2_dist", dist_cm[19:10], 20);
    check("m2_to", timeout[1], 1);
    check("m2_dist0_kept", dist_cm[9:0], 12);
    sel = 3'd1;
    @(negedge clock);
    check("m2_digits", {meters, decimeters, centimeters}, 12'h020);

    // ch0: no echo -> rise timeout after 50 clocks, plus 10 conversion clocks
    wait_trig(c, w);
    check("t3_ch", c, 0);
    wait_valid(n);
    check("m3_latency", n, 60);
    check("m3_valid", valid, 2'b01);
    check("m3_dist", dist_cm[9:0], 0);
    check("m3_to", timeout[0], 1);

    // ch1: reset during MEASURE
    wait_trig(c, w);
    check("t4_ch", c, 1);
    pulse_pin[1] = 1'b1;
    repeat (8) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("r_trig", trigger_pin, 0);
    check("r_dist", dist_cm, 0);
    check("r_to", timeout, 0);
    check("r_valid", valid, 0);
    check("r_digits", {meters, decimeters, centimeters}, 0);
    pulse_pin[1] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    wait_trig(c, w);
    check("t5_ch", c, 0);
    check("t5_width", w, 4);

    // ch0: enable dropped mid-measurement, 9 high clocks -> 3 cm, then idle
    pulse_pin[0] = 1'b1;
    repeat (3) @(negedge clock);
    enable = 1'b0;
    repeat (6) @(negedge clock);
    pulse_pin[0] = 1'b0;
    wait_valid(n);
    check("m5_valid", valid, 2'b01);
    check("m5_dist", dist_cm[9:0], 3);
    check("m5_to", timeout[0], 0);
    n = 0;
    repeat (60) begin
      @(negedge clock);
      if (trigger_pin != 2'b00) n++;
    end
    check("no_retrigger", n, 0);
    sel = 3'd0;
    @(negedge clock);
    check("m5_digits", {meters, decimeters, centimeters}, 12'h003);
    sel = 3'd2;
    @(negedge clock);
    check("sel_oob", {meters, decimeters, centimeters}, 0);
    check("dist1_after_rst", dist_cm[19:10], 0);
    check("overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
